// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer: fetches 16-bit instructions (opcode in [15:10]), drives an external
// ALU, and issues stores to data RAM that are held until acknowledged.
module instr_sequencer #(
  parameter int ADDR_W = 10
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] oInstrAddr,
  input  logic [15:0]       iInstr,
  output logic [15:0]       oAluInstr,
  output logic [7:0]        oAluA,
  output logic [7:0]        oAluB,
  input  logic [7:0]        iAluData,
  input  logic              iAluWriteA,
  input  logic              iAluWriteB,
  input  logic              iAluCa,
  input  logic              iAluCb,
  output logic [7:0]        oRamAddr,
  output logic [7:0]        oRamData,
  output logic              oRamWrite,
  input  logic              iRamAck,
  output logic [7:0]        oRegA,
  output logic [7:0]        oRegB,
  output logic              oCarryA,
  output logic              oCarryB,
  output logic              oHalted
);

  // ALU class occupies 0x01..0x0E: ADDA ADDB SUBA SUBB ANDA ANDB ORA ORB ASLA ASRA ADDCA ADDCB SUBCA SUBCB.
  localparam logic [5:0] OP_ADDA  = 6'h01, OP_ADDB  = 6'h02, OP_SUBA  = 6'h03, OP_SUBB  = 6'h04;
  localparam logic [5:0] OP_ASLA  = 6'h09, OP_ASRA  = 6'h0A;
  localparam logic [5:0] OP_ADDCA = 6'h0B, OP_ADDCB = 6'h0C, OP_SUBCA = 6'h0D, OP_SUBCB = 6'h0E;
  localparam logic [5:0] OP_LDA   = 6'h10, OP_LDB   = 6'h11, OP_STA   = 6'h12, OP_STB   = 6'h13;
  localparam logic [5:0] OP_JMP   = 6'h18, OP_BCA   = 6'h19, OP_BCB   = 6'h1A, OP_HALT  = 6'h3F;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, MEMWAIT, HALT} state_t;

  state_t            state, next;
  logic [ADDR_W-1:0] pc, pc_inc, target;
  logic [15:0]       ir;
  logic [7:0]        reg_a, reg_b, cap_data;
  logic              carry_a, carry_b, cap_wa, cap_wb, cap_ca, cap_cb;
  logic [5:0]        dec_op, ir_op;

  function automatic logic is_alu(input logic [5:0] op);
    return op inside {[OP_ADDA:OP_SUBCB]};
  endfunction

  function automatic logic carry_to_a(input logic [5:0] op);
    return op inside {OP_ADDA, OP_SUBA, OP_ASLA, OP_ASRA, OP_ADDCA, OP_SUBCA};
  endfunction

  function automatic logic carry_to_b(input logic [5:0] op);
    return op inside {OP_ADDB, OP_SUBB, OP_ADDCB, OP_SUBCB};
  endfunction

  assign dec_op     = iInstr[15:10];
  assign ir_op      = ir[15:10];
  assign pc_inc     = pc + ADDR_W'(1);
  assign target     = iInstr[ADDR_W-1:0];
  assign oInstrAddr = pc;
  assign oAluA      = reg_a;
  assign oAluB      = reg_b;
  assign oRegA      = reg_a;
  assign oRegB      = reg_b;
  assign oCarryA    = carry_a;
  assign oCarryB    = carry_b;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= FETCH;
    else        state <= next;
  end

  always_comb begin
    next      = state;
    oAluInstr = NOP_INSTR;
    oRamWrite = 1'b0;
    oRamAddr  = 8'h00;
    oRamData  = 8'h00;
    oHalted   = 1'b0;
    case (state)
      FETCH:     next = DECODE;
      DECODE: begin
        if (dec_op == OP_HALT)                         next = HALT;
        else if (is_alu(dec_op))                       next = EXECUTE;
        else if (dec_op == OP_STA || dec_op == OP_STB) next = MEMWAIT;
        else                                           next = FETCH;
      end
      EXECUTE: begin
        oAluInstr = ir;
        next      = WRITEBACK;
      end
      WRITEBACK: next = FETCH;
      // Store request is purely state-decoded, so an async reset drops it immediately.
      MEMWAIT: begin
        oRamWrite = 1'b1;
        oRamAddr  = ir[7:0];
        oRamData  = (ir_op == OP_STB) ? reg_b : reg_a;
        if (iRamAck) next = FETCH;
      end
      HALT:      oHalted = 1'b1;
      default:   next = FETCH;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc       <= '0;
      ir       <= NOP_INSTR;
      reg_a    <= 8'h00;
      reg_b    <= 8'h00;
      carry_a  <= 1'b0;
      carry_b  <= 1'b0;
      cap_data <= 8'h00;
      cap_wa   <= 1'b0;
      cap_wb   <= 1'b0;
      cap_ca   <= 1'b0;
      cap_cb   <= 1'b0;
    end else begin
      case (state)
        // Non-ALU, non-store instructions resolve straight from the ROM word.
        DECODE: begin
          ir <= iInstr;
          case (dec_op)
            OP_LDA: begin reg_a <= iInstr[7:0]; pc <= pc_inc; end
            OP_LDB: begin reg_b <= iInstr[7:0]; pc <= pc_inc; end
            OP_JMP: pc <= target;
            OP_BCA: pc <= carry_a ? target : pc_inc;
            OP_BCB: pc <= carry_b ? target : pc_inc;
            OP_STA, OP_STB, OP_HALT: ;
            default: if (!is_alu(dec_op)) pc <= pc_inc;
          endcase
        end
        EXECUTE: begin
          cap_data <= iAluData;
          cap_wa   <= iAluWriteA;
          cap_wb   <= iAluWriteB;
          cap_ca   <= iAluCa;
          cap_cb   <= iAluCb;
        end
        WRITEBACK: begin
          if (cap_wa)            reg_a   <= cap_data;
          if (cap_wb)            reg_b   <= cap_data;
          if (carry_to_a(ir_op)) carry_a <= cap_ca;
          if (carry_to_b(ir_op)) carry_b <= cap_cb;
          pc <= pc_inc;
        end
        MEMWAIT: if (iRamAck) pc <= pc_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench: ROM array with registered read, tiny ALU stand-in, RAM ack driven by tasks.
module tb_instr_sequencer;

  logic        Clock, Reset;
  logic [9:0]  oInstrAddr;
  logic [15:0] iInstr, oAluInstr;
  logic [7:0]  oAluA, oAluB, iAluData, oRamAddr, oRamData, oRegA, oRegB;
  logic        iAluWriteA, iAluWriteB, iAluCa, iAluCb;
  logic        oRamWrite, iRamAck, oCarryA, oCarryB, oHalted;

  logic [15:0] rom [0:1023];
  int tests = 0;
  int fails = 0;

  instr_sequencer #(.ADDR_W(10)) dut (
    .Clock(Clock), .Reset(Reset), .oInstrAddr(oInstrAddr), .iInstr(iInstr),
    .oAluInstr(oAluInstr), .oAluA(oAluA), .oAluB(oAluB), .iAluData(iAluData),
    .iAluWriteA(iAluWriteA), .iAluWriteB(iAluWriteB), .iAluCa(iAluCa), .iAluCb(iAluCb),
    .oRamAddr(oRamAddr), .oRamData(oRamData), .oRamWrite(oRamWrite), .iRamAck(iRamAck),
    .oRegA(oRegA), .oRegB(oRegB), .oCarryA(oCarryA), .oCarryB(oCarryB), .oHalted(oHalted)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) iInstr <= rom[oInstrAddr];

  // ALU stand-in: ADDA, SUBCA (borrow as carry, no write), ANDA (drives carry 0).
  always_comb begin
    iAluData = 8'h00; iAluWriteA = 1'b0; iAluWriteB = 1'b0; iAluCa = 1'b0; iAluCb = 1'b0;
    case (oAluInstr[15:10])
      6'h01:   begin {iAluCa, iAluData} = {1'b0, oAluA} + {1'b0, oAluB}; iAluWriteA = 1'b1; end
      6'h05:   begin iAluData = oAluA & oAluB; iAluWriteA = 1'b1; end
      6'h0D:   iAluCa = (oAluA < oAluB);
      default: ;
    endcase
  end

  task automatic clear_rom();
    Reset = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 16'h40F0; rom[1] = 16'hFC00;
    release_reset();
    edges(2);
    tests++; if (oRegA !== 8'hF0) begin fails++; $display("FAIL rst_pre_rega got %h want f0", oRegA); end
    #2 Reset = 1'b0; #1;
    tests++; if (oInstrAddr !== 10'd0) begin fails++; $display("FAIL rst_pc got %h want 0", oInstrAddr); end
    tests++; if ({oRegA, oRegB, oCarryA, oCarryB} !== 18'd0) begin fails++; $display("FAIL rst_regs got %h %h %b %b want 0", oRegA, oRegB, oCarryA, oCarryB); end
    tests++; if ({oRamWrite, oHalted} !== 2'b00) begin fails++; $display("FAIL rst_flags got %b%b want 00", oRamWrite, oHalted); end
    tests++; if (oAluInstr !== 16'h0000) begin fails++; $display("FAIL rst_aluinstr got %h want 0000", oAluInstr); end
  endtask

  task automatic test_alu_add();
    clear_rom();
    rom[0] = 16'h40F0; rom[1] = 16'h4420; rom[2] = 16'h0400; rom[3] = 16'hFC00;
    release_reset();
    edges(2);
    tests++; if (oRegA !== 8'hF0 || oInstrAddr !== 10'd1) begin fails++; $display("FAIL lda got A=%h pc=%h want f0/1", oRegA, oInstrAddr); end
    edges(2);
    tests++; if (oRegB !== 8'h20 || oInstrAddr !== 10'd2) begin fails++; $display("FAIL ldb got B=%h pc=%h want 20/2", oRegB, oInstrAddr); end
    edges(2);
    tests++; if ({oAluInstr, oAluA, oAluB} !== 32'h0400_F020) begin fails++; $display("FAIL exec_drive got %h %h %h want 0400 f0 20", oAluInstr, oAluA, oAluB); end
    edges(1);
    tests++; if (oAluInstr !== 16'h0000 || oRegA !== 8'hF0) begin fails++; $display("FAIL wb_timing got instr=%h A=%h want 0000/f0", oAluInstr, oRegA); end
    edges(1);
    tests++; if ({oRegA, oCarryA, oRegB, oCarryB} !== {8'h10, 1'b1, 8'h20, 1'b0}) begin fails++; $display("FAIL adda got A=%h ca=%b B=%h cb=%b want 10/1/20/0", oRegA, oCarryA, oRegB, oCarryB); end
    tests++; if (oInstrAddr !== 10'd3) begin fails++; $display("FAIL adda_pc got %h want 3", oInstrAddr); end
  endtask

  task automatic test_compare();
    clear_rom();
    rom[0] = 16'h4005; rom[1] = 16'h4407; rom[2] = 16'h3400; rom[3] = 16'h440C; rom[4] = 16'h1400; rom[5] = 16'hFC00;
    release_reset();
    edges(8);
    tests++; if ({oRegA, oCarryA, oRegB, oCarryB} !== {8'h05, 1'b1, 8'h07, 1'b0}) begin fails++; $display("FAIL subca got A=%h ca=%b B=%h cb=%b want 05/1/07/0", oRegA, oCarryA, oRegB, oCarryB); end
    tests++; if (oInstrAddr !== 10'd3) begin fails++; $display("FAIL subca_pc got %h want 3", oInstrAddr); end
    edges(6);
    tests++; if ({oRegA, oCarryA} !== {8'h04, 1'b1}) begin fails++; $display("FAIL anda got A=%h ca=%b want 04/1", oRegA, oCarryA); end
    tests++; if (oInstrAddr !== 10'd5) begin fails++; $display("FAIL anda_pc got %h want 5", oInstrAddr); end
  endtask

  task automatic test_store();
    clear_rom();
    iRamAck = 1'b0;
    rom[0] = 16'h405A; rom[1] = 16'h483C; rom[2] = 16'h4477; rom[3] = 16'h4C10; rom[4] = 16'hFC00;
    release_reset();
    edges(4);
    for (int c = 0; c < 4; c++) begin
      tests++; if ({oRamWrite, oRamAddr, oRamData} !== {1'b1, 8'h3C, 8'h5A}) begin fails++; $display("FAIL sta_hold%0d got %b %h %h want 1 3c 5a", c, oRamWrite, oRamAddr, oRamData); end
      if (c == 3) iRamAck = 1'b1;
      edges(1);
    end
    tests++; if (oRamWrite !== 1'b0 || oInstrAddr !== 10'd2) begin fails++; $display("FAIL sta_done got wr=%b pc=%h want 0/2", oRamWrite, oInstrAddr); end
    edges(2);
    tests++; if (oRegB !== 8'h77 || oInstrAddr !== 10'd3) begin fails++; $display("FAIL ldb_ack_ignored got B=%h pc=%h want 77/3", oRegB, oInstrAddr); end
    edges(2);
    tests++; if ({oRamWrite, oRamAddr, oRamData} !== {1'b1, 8'h10, 8'h77}) begin fails++; $display("FAIL stb got %b %h %h want 1 10 77", oRamWrite, oRamAddr, oRamData); end
    edges(1);
    tests++; if (oRamWrite !== 1'b0 || oInstrAddr !== 10'd4) begin fails++; $display("FAIL stb_done got wr=%b pc=%h want 0/4", oRamWrite, oInstrAddr); end
    iRamAck = 1'b0;
  endtask

  task automatic test_branch();
    clear_rom();
    rom[0] = 16'h40F0; rom[1] = 16'h4420; rom[2] = 16'h0400; rom[3] = 16'h6500; rom[10'h100] = 16'hFC00;
    release_reset();
    edges(10);
    tests++; if (oInstrAddr !== 10'h100) begin fails++; $display("FAIL bca_taken got %h want 100", oInstrAddr); end
    clear_rom();
    rom[0] = 16'h8000; rom[5] = 16'h6500; rom[6] = 16'h63FF;
    release_reset();
    edges(2);
    tests++; if (oInstrAddr !== 10'd1 || oRegA !== 8'h00 || oRamWrite !== 1'b0) begin fails++; $display("FAIL undef_op got pc=%h A=%h wr=%b want 1/00/0", oInstrAddr, oRegA, oRamWrite); end
    edges(10);
    tests++; if (oInstrAddr !== 10'd6) begin fails++; $display("FAIL bca_not_taken got %h want 6", oInstrAddr); end
    edges(2);
    tests++; if (oInstrAddr !== 10'h3FF) begin fails++; $display("FAIL jmp got %h want 3ff", oInstrAddr); end
    edges(2);
    tests++; if (oInstrAddr !== 10'h000) begin fails++; $display("FAIL pc_wrap got %h want 000", oInstrAddr); end
  endtask

  task automatic test_reset_memwait();
    clear_rom();
    iRamAck = 1'b0;
    rom[0] = 16'h405A; rom[1] = 16'h483C; rom[2] = 16'hFC00;
    release_reset();
    edges(5);
    tests++; if (oRamWrite !== 1'b1) begin fails++; $display("FAIL mw_pre got %b want 1", oRamWrite); end
    #2 Reset = 1'b0; #1;
    tests++; if (oRamWrite !== 1'b0 || oRegA !== 8'h00 || oInstrAddr !== 10'd0) begin fails++; $display("FAIL mw_reset got wr=%b A=%h pc=%h want 0/00/0", oRamWrite, oRegA, oInstrAddr); end
    release_reset();
    edges(2);
    tests++; if (oRegA !== 8'h5A || oInstrAddr !== 10'd1 || oRamWrite !== 1'b0) begin fails++; $display("FAIL mw_restart got A=%h pc=%h wr=%b want 5a/1/0", oRegA, oInstrAddr, oRamWrite); end
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0] = 16'h40F0; rom[1] = 16'h4420; rom[2] = 16'h0400; rom[3] = 16'h0000; rom[4] = 16'hFC00; rom[5] = 16'h4011;
    release_reset();
    edges(12);
    tests++; if (oHalted !== 1'b1 || oInstrAddr !== 10'd4) begin fails++; $display("FAIL halt_enter got h=%b pc=%h want 1/4", oHalted, oInstrAddr); end
    iRamAck = 1'b1;
    for (int c = 0; c < 20; c++) begin
      edges(1);
      tests++; if ({oInstrAddr, oRegA, oRegB, oCarryA, oCarryB, oRamWrite, oHalted, oAluInstr} !== {10'd4, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000}) begin fails++; $display("FAIL halt_hold%0d got pc=%h A=%h B=%h ca=%b cb=%b wr=%b h=%b ai=%h", c, oInstrAddr, oRegA, oRegB, oCarryA, oCarryB, oRamWrite, oHalted, oAluInstr); end
    end
    iRamAck = 1'b0;
  endtask

  initial begin
    Clock   = 1'b0;
    Reset   = 1'b0;
    iRamAck = 1'b0;
    test_reset();
    test_alu_add();
    test_compare();
    test_store();
    test_branch();
    test_reset_memwait();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, program-counter / instruction-ROM address width.
REQ-002 SHALL have port Clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port oInstrAddr  output  ADDR_W  instruction ROM address (= PC).
REQ-005 SHALL have port iInstr  input  16  ROM data, valid one cycle after oInstrAddr.
REQ-006 SHALL have port oAluInstr  output  16  instruction word driven to ALU.
REQ-007 SHALL have ports oAluA, oAluB  output  8  ALU operands (= register A, register B).
REQ-008 SHALL have port iAluData  input  8  ALU result.
REQ-009 SHALL have ports iAluWriteA, iAluWriteB, iAluCa, iAluCb  input  1 each  ALU write strobes and carries.
REQ-010 SHALL have ports oRamAddr, oRamData  output  8  data RAM address/data for stores.
REQ-011 SHALL have port oRamWrite  output  1  store request; iRamAck  input  1  store accepted.
REQ-012 SHALL have ports oRegA, oRegB  output  8; oCarryA, oCarryB  output  1; oHalted  output  1.

Function
REQ-013 SHALL implement states FETCH, DECODE, EXECUTE, WRITEBACK, MEMWAIT, HALT.
REQ-014 FETCH: drive oInstrAddr=PC; next state DECODE.
REQ-015 DECODE: latch iInstr into IR; opcode macros from Definitions.v; ALU class (ADD*, SUB*, AND*, OR*, ASLA, ASRA) -> EXECUTE; STA/STB -> MEMWAIT; LDA/LDB/JMP/BCA/BCB/NOP -> resolved in DECODE, next FETCH; HALT -> HALT.
REQ-016 EXECUTE: oAluInstr=IR, oAluA=A, oAluB=B; capture iAluData, strobes, carries at cycle end; next WRITEBACK.
REQ-017 WRITEBACK: A<=captured data if captured iAluWriteA; B<=captured data if captured iAluWriteB; both strobes set -> both written.
REQ-018 Carry rule: ADD*/SUB*/ASLA/ASRA update carry of target side (…A -> CarryA from iAluCa, …B -> CarryB from iAluCb), including compare forms ADDCx/SUBCx; AND*/OR* preserve both carries.
REQ-019 Outside EXECUTE, oAluInstr SHALL be the NOP encoding.
REQ-020 LDA/LDB: A or B <= IR[7:0]; carries unchanged.
REQ-021 JMP: PC<=IR[ADDR_W-1:0]; BCA/BCB: same if CarryA/CarryB=1, else PC+1.
REQ-022 STA/STB: in MEMWAIT assert oRamWrite, oRamAddr=IR[7:0], oRamData=A or B, held stable until iRamAck sampled 1; ack in first MEMWAIT cycle completes in that cycle; oRamWrite deasserts in the following cycle; iRamAck outside MEMWAIT ignored.
REQ-023 PC SHALL increment by 1 on completion of every non-jump instruction; wrap 2^ADDR_W-1 -> 0.
REQ-024 Latency: ALU op 4 cycles; LD/JMP/branch/NOP 2 cycles; store 2 + ack-wait cycles (min 3).
REQ-025 Undefined opcode SHALL behave as NOP.
REQ-026 HALT: oHalted=1, PC frozen, no register/RAM activity until reset.
REQ-027 oRegA/oRegB/oCarryA/oCarryB SHALL be registered copies of architectural state.

Reset
REQ-028 Reset low SHALL immediately force state FETCH, PC=0, IR=0, A=B=0, CarryA=CarryB=0, oRamWrite=0, oHalted=0, oAluInstr=NOP.
REQ-029 Reset during MEMWAIT SHALL drop oRamWrite without waiting for iRamAck; the store is abandoned.
REQ-030 First FETCH SHALL occur on the first rising edge after Reset deasserts.

Verification
REQ-031 Reset release, ROM: LDA 0xF0, LDB 0x20, ADDA -> A=0x10, CarryA=1, B=0x20, PC=3 after 2+2+4 cycles.
REQ-032 A=0x05, B=0x07, SUBCA -> A unchanged 0x05, CarryA=1, no register write.
REQ-033 STA 0x3C with A=0x5A, iRamAck held low 3 cycles then high -> oRamWrite high 4 cycles, addr 0x3C, data 0x5A stable throughout.
REQ-034 CarryA=1, BCA 0x100 -> PC=0x100; CarryA=0, BCA 0x100 at PC=5 -> PC=6; NOP at PC=0x3FF -> PC=0.
REQ-035 Reset asserted mid-MEMWAIT -> oRamWrite=0 same cycle, all registers 0, fetch restarts at PC=0.
REQ-036 HALT at PC=4 -> oHalted=1, oInstrAddr fixed at 4, A/B/carries stable for 20 cycles.
